// File: rtl/ex_redirect.sv
// Execute-stage branch/jump resolver. It issues a registered redirect to fetch,
// then walks the wrong-path slot and the fetch bubble that follow each redirect.
module ex_redirect #(
    parameter bit DELAY_SLOT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_EX,
    input  logic [9:0]  pc_FETCH,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [1:0]  pc_src_EX,
    output logic [9:0]  branch_addr_EX,
    output logic [9:0]  jtype_addr_EX,
    output logic [9:0]  reg_addr_EX,
    output logic        stall_EX,
    output logic        link_we,
    output logic [9:0]  link_addr,
    output logic [15:0] redirect_count
);

    // state    | meaning
    // IDLE     | decode active, redirect issued on a taken branch or any jump
    // REDIRECT | pc_src_EX live; sequential successor is in execute
    // DRAIN    | fetch-inserted bubble in execute
    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_J   = 2'b10;
    localparam logic [1:0] SRC_JR  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_pc_src;
    logic [9:0]  r_branch_addr;
    logic [9:0]  r_jtype_addr;
    logic [9:0]  r_reg_addr;
    logic [15:0] r_count;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [1:0]  w_src_dec;
    logic        w_is_link;
    logic        w_issue;
    logic [9:0]  w_branch_tgt;
    logic        w_unused;

    assign w_opcode     = instruction_EX[31:26];
    assign w_funct      = instruction_EX[5:0];
    assign w_branch_tgt = pc_FETCH + 10'd1 + instruction_EX[9:0];
    assign w_unused     = ^instruction_EX[25:10];

    always_comb begin
        w_src_dec = SRC_SEQ;
        w_is_link = 1'b0;
        case (w_opcode)
            6'b000100: if (rs_data == rt_data)          w_src_dec = SRC_BR;
            6'b000101: if (rs_data != rt_data)          w_src_dec = SRC_BR;
            6'b000110: if ($signed(rs_data) <= 32'sd0)  w_src_dec = SRC_BR;
            6'b000111: if ($signed(rs_data) >  32'sd0)  w_src_dec = SRC_BR;
            6'b000010: w_src_dec = SRC_J;
            6'b000011: begin
                w_src_dec = SRC_J;
                w_is_link = 1'b1;
            end
            6'b000000: begin
                if (w_funct == 6'b001000) begin
                    w_src_dec = SRC_JR;
                end else if (w_funct == 6'b001001) begin
                    w_src_dec = SRC_JR;
                    w_is_link = 1'b1;
                end
            end
            default: w_src_dec = SRC_SEQ;
        endcase
    end

    assign w_issue = (r_state == S_IDLE) && (w_src_dec != SRC_SEQ);

    always_comb begin
        w_state_nxt = r_state;
        stall_EX    = 1'b0;
        link_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                link_we = w_is_link && !rst;
                if (w_issue) w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                stall_EX    = !DELAY_SLOT;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                stall_EX    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // pc_src_EX is non-zero only for the single REDIRECT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_src      <= SRC_SEQ;
            r_branch_addr <= 10'd0;
            r_jtype_addr  <= 10'd0;
            r_reg_addr    <= 10'd0;
            r_count       <= 16'd0;
        end else begin
            r_pc_src <= w_issue ? w_src_dec : SRC_SEQ;
            if (w_issue) begin
                case (w_src_dec)
                    SRC_BR:  r_branch_addr <= w_branch_tgt;
                    SRC_J:   r_jtype_addr  <= instruction_EX[9:0];
                    SRC_JR:  r_reg_addr    <= rs_data[9:0];
                    default: r_reg_addr    <= r_reg_addr;
                endcase
                if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            end
        end
    end

    assign pc_src_EX      = r_pc_src;
    assign branch_addr_EX = r_branch_addr;
    assign jtype_addr_EX  = r_jtype_addr;
    assign reg_addr_EX    = r_reg_addr;
    assign redirect_count = r_count;
    assign link_addr      = link_we ? (pc_FETCH + 10'd1) : 10'd0;

endmodule

// File: doc/ex_redirect.md
# ex_redirect

Execute-stage control-transfer resolver for the three-stage MIPS pipeline; the consumer end of the fetch/execute interface. Each cycle it decodes the word in instruction_EX (tagged with pc_FETCH), resolves branches and jumps using register operands, and drives the registered redirect request (pc_src_EX plus target addresses) back to fetch. It also tracks the wrong-path instruction and the bubble that follow every redirect, and flags both for squash.

## Interface
- DELAY_SLOT, 0, 1 executes the instruction after a control transfer instead of squashing it.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- instruction_EX  in  32  instruction word from fetch; 32'h0 is a NOP/bubble.
- pc_FETCH  in  10  word address of instruction_EX.
- rs_data  in  32  register-file value for instr[25:21].
- rt_data  in  32  register-file value for instr[20:16].
- pc_src_EX  out  2  redirect select: 00 sequential, 01 branch, 10 j/jal, 11 jr/jalr.
- branch_addr_EX  out  10  branch target.
- jtype_addr_EX  out  10  jump target.
- reg_addr_EX  out  10  register target.
- stall_EX  out  1  current instruction_EX is wrong-path/bubble; execute must not commit it.
- link_we  out  1  one-cycle pulse: write link_addr to $31 (jal) or rd (jalr).
- link_addr  out  10  return address, pc_FETCH+1.
- redirect_count  out  16  saturating count of issued redirects.

## Operation
- Decoded opcodes (instr[31:26]): beq 000100, bne 000101, blez 000110, bgtz 000111, j 000010, jal 000011. With opcode 000000, funct instr[5:0] selects jr 001000 and jalr 001001. Everything else is sequential.
- Branch conditions use signed 32-bit compares:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: rs<=0.
  - bgtz: rs>0.
- Targets, all modulo 1024:
  - branch: pc_FETCH + 1 + instr[9:0].
  - jump: instr[9:0].
  - register: rs_data[9:0].
- FSM states:
  - IDLE: decode is active. A taken branch or any jump registers pc_src_EX and the matching target on the next edge, increments redirect_count (holds at 16'hFFFF), and moves to REDIRECT. Not-taken or non-control instructions stay in IDLE with pc_src_EX=00.
  - REDIRECT: lasts one cycle; pc_src_EX is held non-zero. instruction_EX is the sequential successor. stall_EX=1 when DELAY_SLOT=0, 0 when DELAY_SLOT=1. Decode is disabled, so a control transfer in this slot is ignored. Next state is DRAIN, and pc_src_EX returns to 00 on that edge.
  - DRAIN: lasts one cycle; instruction_EX is the fetch-inserted 32'h0. stall_EX=1, decode disabled. Next state is IDLE.
- Target outputs update only when a redirect is issued and hold otherwise. Only the target selected by pc_src_EX is meaningful.
- link_we pulses in the same cycle jal/jalr is decoded in IDLE (combinational from decode, gated by state==IDLE). It does not fire for wrong-path instructions.
- pc_src_EX is never 11 and 01 in consecutive cycles, so fetch priority never matters.

## Timing
- Reset: state IDLE; pc_src_EX=00; all addresses 0; redirect_count 0; stall_EX 0; link_we 0. Reset asserted mid-REDIRECT or mid-DRAIN aborts to IDLE immediately.
- Decode to pc_src_EX valid: 1 edge. pc_src_EX is non-zero for exactly 1 cycle.
- Full redirect sequence (control instruction in IDLE at cycle n):
  - n+1: REDIRECT.
  - n+2: DRAIN.
  - n+3: target instruction arrives.
  - Penalty: 2 cycles (1 with DELAY_SLOT=1).
- Back-to-back control transfers: the second is squashed if it falls in REDIRECT. It executes only if DELAY_SLOT=1 and it is not a control transfer; control transfers in a delay slot are ignored.
- Arithmetic wrap: pc_FETCH=1023, imm=0 gives target 0.
- redirect_count saturates at 16'hFFFF.

## Test plan
- Reset: assert rst mid-REDIRECT -> pc_src_EX=00, stall_EX=0, redirect_count=0 immediately, with no clock edge.
- beq taken: pc_FETCH=10, instr 0x1085_0005, rs=rt=7 -> next cycle pc_src_EX=01, branch_addr_EX=16; stall_EX=1 for 2 cycles; redirect_count=1.
- bne not taken: rs=rt=3 -> pc_src_EX stays 00, no stall, count unchanged.
- jal: pc_FETCH=20, instr 0x0C00_0040 -> link_we=1 with link_addr=21 the same cycle; next cycle pc_src_EX=10, jtype_addr_EX=64.
- jr followed by j in REDIRECT slot: rs_data=0x0000_03FF -> pc_src_EX=11, reg_addr_EX=1023; the j is ignored; with DELAY_SLOT=0, stall_EX=1.
- Wrap and saturation:
  - bgtz with rs=1 at pc_FETCH=1023, imm=0 -> branch_addr_EX=0.
  - Preload 65535 redirects -> count holds at 16'hFFFF.
